// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the state encoding, the canonical NOP and the PC width.
package fetch_pkg;

   localparam int XLEN = 64;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      HALT_END = 2'd1,
      HALT_ERR = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction memory bus between the fetch sequencer and the memory.
// The memory answers combinationally for the address it is given.
interface fetch_sequencer_if;
   import fetch_pkg::*;

   logic [XLEN-1:0] inst_address;
   logic [31:0]     instruction;

   modport master (
      output inst_address,
      input  instruction
   );

   modport slave (
      input  inst_address,
      output instruction
   );

endinterface

// File: rtl/fetch_sequencer_sat_counter.sv
// 32-bit saturating up-counter with a hold enable.
// Sticks at all-ones rather than wrapping.
module sat_counter (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        en,
   output logic [31:0] count
);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count <= '0;
      end else if (en && (count != 32'hFFFF_FFFF)) begin
         count <= count + 32'd1;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencer and IF/ID register for the fetch stage.
// Events are decoded one-hot, then applied by a single state machine.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int              IMEM_BYTES = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                stall,
   input  logic                redirect,
   input  logic [XLEN-1:0]     redirect_pc,
   fetch_sequencer_if.master   imem,
   output logic [XLEN-1:0]     ifid_pc,
   output logic [31:0]         ifid_instr,
   output logic                ifid_valid,
   output logic                halted,
   output logic                misalign_err,
   output logic [31:0]         fetch_count
);

   localparam logic [XLEN-1:0] PC_LAST = XLEN'(IMEM_BYTES - 4);

   fetch_state_e    state;
   logic [XLEN-1:0] pc;

   logic aligned;
   logic in_range;
   logic ev_bad;
   logic ev_jump;
   logic ev_end;
   logic ev_step;

   assign imem.inst_address = pc;
   assign halted            = (state != RUN);

   assign aligned  = (redirect_pc[1:0] == 2'b00);
   assign in_range = (pc <= PC_LAST);

   // Priority is folded in here so the FSM sees mutually exclusive events.
   always_comb begin
      ev_bad  = 1'b0;
      ev_jump = 1'b0;
      ev_end  = 1'b0;
      ev_step = 1'b0;
      if (state != HALT_ERR && redirect) begin
         ev_bad  = !aligned;
         ev_jump = aligned;
      end else if (state == RUN && !stall) begin
         ev_end  = !in_range;
         ev_step = in_range;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= RUN;
         pc           <= RESET_PC;
         ifid_pc      <= '0;
         ifid_instr   <= NOP;
         ifid_valid   <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         unique case (1'b1)
            ev_bad: begin
               state        <= HALT_ERR;
               misalign_err <= 1'b1;
               ifid_valid   <= 1'b0;
               ifid_instr   <= NOP;
            end
            ev_jump: begin
               state      <= RUN;
               pc         <= redirect_pc;
               ifid_valid <= 1'b0;
               ifid_instr <= NOP;
            end
            ev_end: begin
               state      <= HALT_END;
               ifid_valid <= 1'b0;
               ifid_instr <= NOP;
            end
            ev_step: begin
               ifid_pc    <= pc;
               ifid_instr <= imem.instruction;
               ifid_valid <= 1'b1;
               pc         <= pc + XLEN'(4);
            end
            default: begin
            end
         endcase
      end
   end

   sat_counter u_fetch_count (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (ev_step),
      .count   (fetch_count)
   );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed table, random run against a model,
// and a saturation sequence on the fetch counter.
module tb_fetch_sequencer;
   import fetch_pkg::*;

   localparam int IMEM_BYTES = 32;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [63:0] redirect_pc = '0;

   logic [63:0] ifid_pc;
   logic [31:0] ifid_instr;
   logic        ifid_valid;
   logic        halted;
   logic        misalign_err;
   logic [31:0] fetch_count;

   logic [31:0] mem [8];

   fetch_sequencer_if imem ();

   assign imem.instruction = (imem.inst_address < 64'd32) ?
      mem[imem.inst_address[4:2]] : 32'hDEAD_BEEF;

   fetch_sequencer #(
      .IMEM_BYTES (IMEM_BYTES),
      .RESET_PC   (64'h0)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .stall        (stall),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .imem         (imem.master),
      .ifid_pc      (ifid_pc),
      .ifid_instr   (ifid_instr),
      .ifid_valid   (ifid_valid),
      .halted       (halted),
      .misalign_err (misalign_err),
      .fetch_count  (fetch_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behavioural reference: what the fetch stage should look like.
   logic [63:0] m_pc, m_ifid_pc;
   logic [31:0] m_instr;
   logic        m_valid, m_flag;
   bit          m_stopped_end, m_stopped_err;
   longint      m_cnt;

   task automatic m_step();
      if (!reset_n) begin
         m_pc = 0; m_ifid_pc = 0; m_instr = NOP; m_valid = 0;
         m_flag = 0; m_cnt = 0; m_stopped_end = 0; m_stopped_err = 0;
      end else if (m_stopped_err) begin
      end else if (redirect && redirect_pc[1:0] != 0) begin
         m_stopped_err = 1; m_flag = 1; m_valid = 0; m_instr = NOP;
      end else if (redirect) begin
         m_pc = redirect_pc; m_stopped_end = 0; m_valid = 0; m_instr = NOP;
      end else if (m_stopped_end || stall) begin
      end else if (m_pc > 64'(IMEM_BYTES - 4)) begin
         m_stopped_end = 1; m_valid = 0; m_instr = NOP;
      end else begin
         m_ifid_pc = m_pc;
         m_instr   = mem[m_pc / 4];
         m_valid   = 1;
         m_pc      = m_pc + 4;
         m_cnt     = (m_cnt >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + 1;
      end
   endtask

   task automatic m_check(int cyc);
      string t;
      t = $sformatf("rnd%0d", cyc);
      chk({t, " addr"},   imem.inst_address, m_pc);
      chk({t, " ifid_pc"}, ifid_pc, m_ifid_pc);
      chk({t, " instr"},  {32'h0, ifid_instr}, {32'h0, m_instr});
      chk({t, " valid"},  {63'h0, ifid_valid}, {63'h0, m_valid});
      chk({t, " halted"}, {63'h0, halted},
          {63'h0, m_stopped_end | m_stopped_err});
      chk({t, " err"},    {63'h0, misalign_err}, {63'h0, m_flag});
      chk({t, " count"},  {32'h0, fetch_count}, m_cnt);
   endtask

   typedef struct {
      logic        rst_n, stl, rdr;
      logic [63:0] rpc;
      logic [63:0] addr, ipc;
      logic [31:0] instr;
      logic        v, h, e;
      logic [31:0] cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic s, logic d, logic [63:0] rp,
                               logic [63:0] a, logic [63:0] ip,
                               logic [31:0] in, logic v, logic h,
                               logic e, logic [31:0] c);
      vec_t x;
      x = '{r, s, d, rp, a, ip, in, v, h, e, c};
      return x;
   endfunction

   function automatic logic [31:0] aw(int i);
      return 32'hA000_0000 + 32'(i);
   endfunction

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = aw(i);

      // reset, free run, stall at PC=8, resume
      tbl.push_back(mk(0,0,0,0,  'h0, 'h0, NOP,   0,0,0,0));
      tbl.push_back(mk(1,0,0,0,  'h4, 'h0, aw(0), 1,0,0,1));
      tbl.push_back(mk(1,0,0,0,  'h8, 'h4, aw(1), 1,0,0,2));
      tbl.push_back(mk(1,1,0,0,  'h8, 'h4, aw(1), 1,0,0,2));
      tbl.push_back(mk(1,1,0,0,  'h8, 'h4, aw(1), 1,0,0,2));
      tbl.push_back(mk(1,1,0,0,  'h8, 'h4, aw(1), 1,0,0,2));
      tbl.push_back(mk(1,0,0,0,  'hC, 'h8, aw(2), 1,0,0,3));
      tbl.push_back(mk(1,0,0,0, 'h10, 'hC, aw(3), 1,0,0,4));
      // reset beats stall and a misaligned redirect
      tbl.push_back(mk(0,1,1,6,  'h0, 'h0, NOP,   0,0,0,0));
      tbl.push_back(mk(1,0,0,0,  'h4, 'h0, aw(0), 1,0,0,1));
      // redirect with stall inserts a bubble
      tbl.push_back(mk(1,1,1,'h10, 'h10, 'h0, NOP, 0,0,0,1));
      tbl.push_back(mk(1,0,0,0, 'h14, 'h10, aw(4), 1,0,0,2));
      tbl.push_back(mk(1,0,0,0, 'h18, 'h14, aw(5), 1,0,0,3));
      tbl.push_back(mk(1,0,0,0, 'h1C, 'h18, aw(6), 1,0,0,4));
      tbl.push_back(mk(1,0,0,0, 'h20, 'h1C, aw(7), 1,0,0,5));
      // run off the end, stall ignored, redirect back
      tbl.push_back(mk(1,0,0,0, 'h20, 'h1C, NOP, 0,1,0,5));
      tbl.push_back(mk(1,1,0,0, 'h20, 'h1C, NOP, 0,1,0,5));
      tbl.push_back(mk(1,0,1,0,  'h0, 'h1C, NOP, 0,0,0,5));
      tbl.push_back(mk(1,0,0,0,  'h4, 'h0, aw(0), 1,0,0,6));
      // misaligned redirect is terminal until reset
      tbl.push_back(mk(1,0,1,6,  'h4, 'h0, NOP, 0,1,1,6));
      tbl.push_back(mk(1,0,1,0,  'h4, 'h0, NOP, 0,1,1,6));
      tbl.push_back(mk(1,0,0,0,  'h4, 'h0, NOP, 0,1,1,6));
      tbl.push_back(mk(0,0,0,0,  'h0, 'h0, NOP, 0,0,0,0));

      @(negedge clk);
      foreach (tbl[i]) begin
         reset_n = tbl[i].rst_n; stall = tbl[i].stl;
         redirect = tbl[i].rdr; redirect_pc = tbl[i].rpc;
         @(posedge clk); #1;
         chk($sformatf("v%0d addr", i), imem.inst_address, tbl[i].addr);
         chk($sformatf("v%0d ifid_pc", i), ifid_pc, tbl[i].ipc);
         chk($sformatf("v%0d instr", i), {32'h0, ifid_instr},
             {32'h0, tbl[i].instr});
         chk($sformatf("v%0d valid", i), {63'h0, ifid_valid},
             {63'h0, tbl[i].v});
         chk($sformatf("v%0d halted", i), {63'h0, halted},
             {63'h0, tbl[i].h});
         chk($sformatf("v%0d err", i), {63'h0, misalign_err},
             {63'h0, tbl[i].e});
         chk($sformatf("v%0d count", i), {32'h0, fetch_count},
             {32'h0, tbl[i].cnt});
      end

      // random run against the model
      for (int i = 0; i < 8; i++) mem[i] = $urandom;
      reset_n = 0; stall = 0; redirect = 0; redirect_pc = 0;
      m_step(); @(posedge clk); #1; m_check(-1);
      for (int c = 0; c < 3000; c++) begin
         reset_n  = ($urandom_range(0, 39) != 0);
         stall    = ($urandom_range(0, 3) == 0);
         redirect = ($urandom_range(0, 7) == 0);
         redirect_pc = 64'(4 * $urandom_range(0, 10));
         if ($urandom_range(0, 15) == 0)
            redirect_pc[1:0] = 2'($urandom_range(1, 3));
         m_step(); @(posedge clk); #1; m_check(c);
      end

      // saturation of the fetch counter
      reset_n = 0; stall = 0; redirect = 0;
      @(posedge clk); #1;
      reset_n = 1; stall = 1;
      @(negedge clk);
      force dut.u_fetch_count.count = 32'hFFFF_FFFE;
      #1 release dut.u_fetch_count.count;
      #1 chk("sat preload", {32'h0, fetch_count}, 64'hFFFF_FFFE);
      stall = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk($sformatf("sat step%0d", k), {32'h0, fetch_count},
             64'hFFFF_FFFF);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter IMEM_BYTES, 32, size of the byte-addressed instruction memory; legal fetch addresses are 0..IMEM_BYTES-4.
REQ-002 Parameter RESET_PC, 64'h0, PC value loaded on reset.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset_n  in  1  synchronous active-low reset.
REQ-006 stall  in  1  hazard-unit hold request for PC and IF/ID.
REQ-007 redirect  in  1  taken branch/jump from EX.
REQ-008 redirect_pc  in  64  target byte address for redirect.
REQ-009 inst_address  out  64  byte address to instruction memory; equals current PC combinationally.
REQ-010 instruction  in  32  little-endian word returned combinationally by memory for inst_address.
REQ-011 ifid_pc  out  64  PC of the instruction held in IF/ID.
REQ-012 ifid_instr  out  32  instruction held in IF/ID.
REQ-013 ifid_valid  out  1  IF/ID holds a real instruction.
REQ-014 halted  out  1  high whenever state is not RUN.
REQ-015 misalign_err  out  1  sticky flag for a misaligned redirect target.
REQ-016 fetch_count  out  32  number of instructions loaded into IF/ID, saturating.

Function
REQ-017 States SHALL be RUN, HALT_END and HALT_ERR.
REQ-018 Event priority SHALL be reset > redirect > stall > out-of-range > normal advance.
REQ-019 RUN, normal advance: ifid_pc<=PC, ifid_instr<=instruction, ifid_valid<=1, PC<=PC+4, fetch_count+1; latency from PC to IF/ID is 1 cycle.
REQ-020 fetch_count SHALL saturate at 32'hFFFFFFFF and never wrap.
REQ-021 stall (no redirect): PC, IF/ID registers and fetch_count SHALL hold their values.
REQ-022 Aligned redirect (redirect_pc[1:0]==0): PC<=redirect_pc, ifid_valid<=0, ifid_instr<=NOP (32'h00000013), and fetch_count holds.
REQ-023 redirect and stall in the same cycle: the redirect SHALL win and the IF/ID bubble SHALL be inserted.
REQ-024 Misaligned redirect in any non-reset state: the next state is HALT_ERR, misalign_err<=1, PC holds, and ifid_valid<=0.
REQ-025 RUN with PC > IMEM_BYTES-4 and no redirect: the next state is HALT_END, PC holds, ifid_valid<=0, and ifid_instr<=NOP.
REQ-026 HALT_END: an aligned redirect SHALL return the block to RUN with PC<=redirect_pc; stall has no effect.
REQ-027 HALT_ERR SHALL be exited only by reset; aligned redirects are ignored there.
REQ-028 An out-of-range redirect target SHALL be accepted; the block enters HALT_END on the following cycle per REQ-025.
REQ-029 PC+4 SHALL use 64-bit unsigned arithmetic, with wrap at 2^64 permitted; the range check covers the wrapped value.

Reset
REQ-030 When reset_n=0 at a clock edge, the following SHALL apply: PC<=RESET_PC, state<=RUN, ifid_pc<=0, ifid_instr<=NOP, ifid_valid<=0, misalign_err<=0, fetch_count<=0.
REQ-031 Reset asserted mid-operation SHALL override simultaneous stall and redirect and SHALL discard the IF/ID contents.
REQ-032 The first fetch after reset deassertion SHALL present RESET_PC on inst_address in the same cycle.

Structure
REQ-033 A shared package fetch_pkg SHALL hold the state encoding, the NOP constant (32'h00000013), and the PC width constant (64).
REQ-034 One sub-module, sat_counter (32-bit saturating increment with hold enable), SHALL implement fetch_count; all other logic is flat.

Verification
REQ-035 Reset, then 4 free-running cycles with IMEM_BYTES=32 -> inst_address 0,4,8,12; ifid_pc 0,4,8 with valid=1; fetch_count=3.
REQ-036 Stall held 3 cycles at PC=8 -> PC=8, ifid_pc=4 and fetch_count held; the block resumes at 12 after stall drops.
REQ-037 Redirect to 0x10 together with stall at PC=4 -> next cycle PC=0x10, ifid_valid=0, ifid_instr=0x00000013.
REQ-038 Free-run to PC=32 -> HALT_END, halted=1, ifid_valid=0; then redirect to 0 -> RUN with PC=0.
REQ-039 Redirect to 0x6 -> HALT_ERR, misalign_err=1; a later redirect to 0x0 is ignored; reset_n=0 clears the flag and returns PC to 0.
REQ-040 Force fetch_count to 32'hFFFFFFFE, advance 3 cycles -> fetch_count=32'hFFFFFFFF with no wrap.
